// File: rtl/game_pkg.sv
// game_pkg -- constants shared by the game-side RTL.
//   BTN_* : bit positions inside the 6-bit button vector
//           {carry, chop, down, up, right, left}.
//   DEBOUNCE_DEFAULT / REPEAT_DEFAULT : default timing parameters.
//   cnt_width() : counter width able to hold n-1, never narrower than 1 bit.
package game_pkg;

  localparam int unsigned NUM_BTN   = 6;
  localparam int unsigned BTN_LEFT  = 0;
  localparam int unsigned BTN_RIGHT = 1;
  localparam int unsigned BTN_UP    = 2;
  localparam int unsigned BTN_DOWN  = 3;
  localparam int unsigned BTN_CHOP  = 4;
  localparam int unsigned BTN_CARRY = 5;

  // 10 ms at 65 MHz
  localparam int unsigned DEBOUNCE_DEFAULT = 650000;
  localparam int unsigned REPEAT_DEFAULT   = 15;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/player_input_if.sv
// player_input_if -- frame marker, raw buttons and conditioned player inputs.
//   vsync_in   : frame marker (rising edge = frame boundary)
//   btn_in     : raw buttons {carry, chop, down, up, right, left}
//   left/right/up/down : frame-stable direction levels
//   chop/carry : one-frame press pulses
//   frame_tick : one-cycle pulse after each vsync_in rising edge
// master drives vsync_in/btn_in; slave (player_input) drives the rest.
interface player_input_if;

  logic       vsync_in;
  logic [5:0] btn_in;
  logic       left;
  logic       right;
  logic       up;
  logic       down;
  logic       chop;
  logic       carry;
  logic       frame_tick;

  modport master (
    output vsync_in, btn_in,
    input  left, right, up, down, chop, carry, frame_tick
  );

  modport slave (
    input  vsync_in, btn_in,
    output left, right, up, down, chop, carry, frame_tick
  );

endinterface

// File: rtl/debounce.sv
// debounce -- 2-FF synchronizer followed by a stability counter.
//   clk_in    : system clock
//   reset_n   : asynchronous active-low reset
//   noisy_in  : raw asynchronous input
//   clean_out : debounced level; follows the synced input only after it has
//               differed from clean_out for DEBOUNCE_CYCLES consecutive cycles
module debounce
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic noisy_in,
  output logic clean_out
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      cnt       <= '0;
      clean_out <= 1'b0;
    end else begin
      sync1 <= noisy_in;
      sync2 <= sync1;
      if (sync2 == clean_out) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        clean_out <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_input.sv
// player_input -- button conditioning for the vsync-clocked game logic.
//   clk_in  : system pixel clock
//   reset_n : asynchronous active-low reset
//   bus     : player_input_if.slave (vsync_in, btn_in in; conditioned
//             directions, chop/carry pulses and frame_tick out)
// Buttons are synchronized and debounced per bit; outputs only change on the
// cycle after a vsync_in rising edge. Directions are levels with opposing
// pairs masked to 0; chop/carry are one-frame pulses from pending flags.
// Build option: PLAYER_INPUT_REPEAT_EN adds chop auto-repeat every
// REPEAT_FRAMES frames while chop is held.
module player_input
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned REPEAT_FRAMES   = REPEAT_DEFAULT
) (
  input  logic           clk_in,
  input  logic           reset_n,
  player_input_if.slave  bus
);

  logic [NUM_BTN-1:0] clean;
  logic               chop_d;
  logic               carry_d;
  logic               vsync_d;
  logic               frame_edge;
  logic               press_chop;
  logic               press_carry;
  logic               pend_chop;
  logic               pend_carry;
  logic               rpt_fire;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_in    (clk_in),
      .reset_n   (reset_n),
      .noisy_in  (bus.btn_in[i]),
      .clean_out (clean[i])
    );
  end

  assign frame_edge  = bus.vsync_in & ~vsync_d;
  assign press_chop  = clean[BTN_CHOP]  & ~chop_d;
  assign press_carry = clean[BTN_CARRY] & ~carry_d;

`ifdef PLAYER_INPUT_REPEAT_EN
  localparam int unsigned   RW       = cnt_width(REPEAT_FRAMES);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_FRAMES - 1);

  logic [RW-1:0] rpt_cnt;

  // The press frame itself advances the count, so the re-arm lands on the
  // boundary before frame REPEAT_FRAMES and chop pulses in that frame.
  assign rpt_fire = frame_edge & clean[BTN_CHOP] & (rpt_cnt == RPT_LAST);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt <= '0;
    end else if (!clean[BTN_CHOP] || press_chop) begin
      rpt_cnt <= '0;
    end else if (frame_edge) begin
      rpt_cnt <= (rpt_cnt == RPT_LAST) ? '0 : rpt_cnt + 1'b1;
    end
  end
`else
  // REPEAT_FRAMES has no effect in this build; it is kept in the parameter
  // list so both builds instantiate identically.
  assign rpt_fire = 1'b0 && (REPEAT_FRAMES != 0);
`endif

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      vsync_d        <= 1'b0;
      chop_d         <= 1'b0;
      carry_d        <= 1'b0;
      pend_chop      <= 1'b0;
      pend_carry     <= 1'b0;
      bus.frame_tick <= 1'b0;
      bus.left       <= 1'b0;
      bus.right      <= 1'b0;
      bus.up         <= 1'b0;
      bus.down       <= 1'b0;
      bus.chop       <= 1'b0;
      bus.carry      <= 1'b0;
    end else begin
      vsync_d        <= bus.vsync_in;
      chop_d         <= clean[BTN_CHOP];
      carry_d        <= clean[BTN_CARRY];
      bus.frame_tick <= frame_edge;

      // Outputs load on the same edge that raises frame_tick.
      if (frame_edge) begin
        bus.left  <= clean[BTN_LEFT]  & ~clean[BTN_RIGHT];
        bus.right <= clean[BTN_RIGHT] & ~clean[BTN_LEFT];
        bus.up    <= clean[BTN_UP]    & ~clean[BTN_DOWN];
        bus.down  <= clean[BTN_DOWN]  & ~clean[BTN_UP];
        bus.chop  <= pend_chop;
        bus.carry <= pend_carry;
      end

      // A new press wins over the boundary clear, deferring it one frame.
      pend_chop  <= press_chop | rpt_fire | (pend_chop & ~frame_edge);
      pend_carry <= press_carry | (pend_carry & ~frame_edge);
    end
  end

endmodule

// File: tb/tb_player_input.sv
// tb_player_input -- directed bench for player_input with a per-frame
// scoreboard: expected output vectors {carry,chop,down,up,right,left} are
// queued as stimulus is applied and compared at each frame_tick.
module tb_player_input;

  localparam int unsigned DC     = 4;
  localparam int unsigned RF     = 3;
  localparam int unsigned FRAME  = 100;
  localparam int unsigned VS_LEN = 10;

`ifdef PLAYER_INPUT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  typedef struct {
    logic [5:0] outs;
    string      tag;
  } exp_t;

  logic clk_in = 1'b0;
  logic reset_n = 1'b0;

  player_input_if bus ();

  player_input #(
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_FRAMES   (RF)
  ) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned pos = FRAME - 1;
  logic [5:0]  last_exp = '0;
  bit          last_valid = 1'b0;
  bit          tick_chk = 1'b0;

  function automatic logic [5:0] outs_now();
    return {bus.carry, bus.chop, bus.down, bus.up, bus.right, bus.left};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] o, input string tag);
    exp_t e;
    e.outs = o;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic goto_pos(input int unsigned k);
    int unsigned n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (pos != k && n < 2 * FRAME);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb_q.size() != 0 && n < 20 * FRAME) begin
      @(negedge clk_in);
      n++;
    end
    check("sb_drain", sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Free-running frame: vsync_in high for positions 0..VS_LEN-1.
  initial begin
    bus.vsync_in = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      pos = (pos == FRAME - 1) ? 0 : pos + 1;
      bus.vsync_in = (pos < VS_LEN);
    end
  end

  // Monitor: frame_tick placement, scoreboard pops, mid-frame hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (tick_chk) check("frame_tick_pos", bus.frame_tick, (pos == 1));
      if (reset_n && bus.frame_tick) begin
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check(e.tag, outs_now(), e.outs);
          last_exp   = e.outs;
          last_valid = 1'b1;
        end else begin
          last_valid = 1'b0;
        end
      end
      if (reset_n && pos == 40 && last_valid) check("hold_mid_frame", outs_now(), last_exp);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rep_exp;
    bus.btn_in = '0;
    reset_n    = 1'b0;
    repeat (3) @(negedge clk_in);
    check("reset_state", {outs_now(), bus.frame_tick}, 7'h00);

    goto_pos(20);
    reset_n  = 1'b1;
    tick_chk = 1'b1;
    push(6'h00, "idle");
    drain();

    // Left hold from cycle 10, release mid-frame
    goto_pos(10);
    bus.btn_in[0] = 1'b1;
    push(6'h01, "left_first");
    drain();
    push(6'h01, "left_held");
    drain();
    goto_pos(30);
    bus.btn_in[0] = 1'b0;
    push(6'h00, "left_release");
    drain();

    // Glitch shorter than DEBOUNCE_CYCLES
    goto_pos(20);
    bus.btn_in[0] = 1'b1;
    repeat (3) @(negedge clk_in);
    bus.btn_in[0] = 1'b0;
    push(6'h00, "glitch_f1");
    push(6'h00, "glitch_f2");
    drain();

    // Two chop presses in one frame
    goto_pos(20);
    bus.btn_in[4] = 1'b1;
    goto_pos(30);
    bus.btn_in[4] = 1'b0;
    goto_pos(45);
    bus.btn_in[4] = 1'b1;
    goto_pos(55);
    bus.btn_in[4] = 1'b0;
    push(6'h10, "chop_collapse");
    push(6'h00, "chop_after");
    drain();

    // Press event lands on the frame_tick edge (94 + 7 cycles)
    goto_pos(94);
    bus.btn_in[4] = 1'b1;
    push(6'h00, "tick_press_f0");
    push(6'h10, "tick_press_f1");
    push(6'h00, "tick_press_f2");
    drain();
    bus.btn_in[4] = 1'b0;

    // Reset mid-frame drops a pending chop
    goto_pos(20);
    bus.btn_in[4] = 1'b1;
    goto_pos(30);
    bus.btn_in[4] = 1'b0;
    goto_pos(50);
    reset_n    = 1'b0;
    tick_chk   = 1'b0;
    last_valid = 1'b0;
    #1;
    check("reset_discard_outs", {outs_now(), bus.frame_tick}, 7'h00);
    goto_pos(70);
    reset_n  = 1'b1;
    tick_chk = 1'b1;
    push(6'h00, "reset_discard");
    drain();

    // All buttons: conflicts masked, chop/carry pulse
    goto_pos(20);
    bus.btn_in = 6'h3F;
    push(6'h30, "all_pressed");
    drain();
    goto_pos(60);
    reset_n    = 1'b0;
    tick_chk   = 1'b0;
    last_valid = 1'b0;
    #1;
    check("reset_mid_frame", {outs_now(), bus.frame_tick}, 7'h00);
    goto_pos(70);
    reset_n  = 1'b1;
    tick_chk = 1'b1;
    push(6'h30, "reset_held_press");
    push(6'h00, "reset_held_after");
    drain();
    goto_pos(20);
    bus.btn_in = '0;
    push(6'h00, "all_released");
    drain();

    // Chop held for 10 frames
    goto_pos(20);
    bus.btn_in[4] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rep_exp = (REP_EN ? (i % RF == 0) : (i == 0)) ? 6'h10 : 6'h00;
      push(rep_exp, $sformatf("repeat_f%0d", i));
    end
    drain();
    bus.btn_in[4] = 1'b0;
    push(6'h00, "repeat_after");
    drain();

    tick_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/player_input.md
# player_input

Input conditioning stage directly upstream of the game logic. Synchronizes and debounces the six raw board buttons. It presents left/right/up/down as frame-stable levels and chop/carry as one-frame pulses. Outputs change only at frame boundaries (vsync rising edge), so the vsync-clocked player movement and state logic sees each input exactly once and never mid-frame.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 650000: number of consecutive stable clk_in cycles required to accept a button change (10 ms at 65 MHz).
- REPEAT_FRAMES, default 15: chop auto-repeat period in frames. Used only when PLAYER_INPUT_REPEAT_EN is defined.

Ports:
- clk_in, input, 1: system pixel clock.
- reset_n, input, 1: reset. Asynchronous assert, active-low.
- vsync_in, input, 1: frame marker, same clock domain, active-high. A rising edge marks a frame boundary.
- btn_in, input, 6: raw asynchronous buttons as {carry, chop, down, up, right, left}, active-high.
- left, right, up, down, output, 1 each: debounced direction levels, frame-stable.
- chop, carry, output, 1 each: press pulses, high for exactly one frame.
- frame_tick, output, 1: single-cycle pulse on the clk_in cycle after each vsync_in rising edge.

## Operation

- **Synchronizer:** each btn_in bit passes through a 2-FF synchronizer.
- **Debounce (per bit):**
  - A counter clears whenever the synced bit equals the debounced state.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced state takes the synced value and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- **Press event:** a debounced 0->1 transition on the chop or carry bit.
- **Pending flags:**
  - A press event on chop or carry sets that bit's pending flag.
  - Multiple presses within one frame collapse into a single pulse.
- **Frame boundary:** detected by registering vsync_in once (vsync_d). The boundary is vsync_in & ~vsync_d; frame_tick is registered from it.
- **Updates on frame_tick:**
  - Direction outputs load the current debounced levels.
  - chop/carry load their pending flags.
  - The pending flags clear.
- **Press on the frame_tick cycle:** if a press event occurs in the same cycle as frame_tick, the pending flag ends up set. The event is carried to the next frame, never lost.
- **Opposing directions:** if left and right are both debounced high, both outputs load 0. Up and down are handled the same way.
- **Outside frame_tick:** all six outputs hold their values.
- **Reset:**
  - All sync FFs, debounced states, counters, pending flags, vsync_d, repeat counters and outputs go to 0.
  - A button held through reset release is debounced as a fresh press and produces one chop/carry pulse.
  - Reset mid-frame discards pending events.

## Timing

- **Press latency:** button edge to output is 2 (sync) + DEBOUNCE_CYCLES + 1 (register) cycles, plus the wait for the next frame_tick. The output changes 1 cycle after the vsync_in rising edge.
- **Pulse length:** chop/carry stay high from one frame_tick to the next, i.e. exactly one frame.
- **Glitch rejection:** glitches shorter than DEBOUNCE_CYCLES never reach any output.
- **vsync_in held high:** produces one frame_tick only.

## Configuration

- **PLAYER_INPUT_REPEAT_EN defined:**
  - While chop stays debounced high, a per-frame counter counts frame_ticks after the press frame.
  - Every REPEAT_FRAMES frames the counter sets pending-chop again, so chop pulses once every REPEAT_FRAMES frames.
  - The counter clears on release.
  - Carry never repeats.
- **Undefined:** exactly one chop pulse per press. No repeat counter is synthesized.

## Structure

- **Shared package (game_pkg):**
  - Button index constants BTN_LEFT=0, BTN_RIGHT=1, BTN_UP=2, BTN_DOWN=3, BTN_CHOP=4, BTN_CARRY=5.
  - Default debounce constant.
- **Sub-module `debounce`:** one instance per button. Parameter DEBOUNCE_CYCLES; ports clk_in, reset_n, noisy_in, clean_out. The sync FFs live inside it.
- Top-level logic holds edge detection, pending flags, frame latching, direction conflict masking and the repeat counter.

## Test plan

Bench uses DEBOUNCE_CYCLES=4, REPEAT_FRAMES=3, and a frame of 100 cycles.

1. **Reset:** assert reset_n=0 mid-frame with btn_in=6'h3F -> all outputs 0. After release, chop=carry=1 for exactly one frame; left/right/up/down masked to 0 because of the conflict rule.
2. **Glitch rejection:** 3-cycle pulse on btn_in[0] -> left stays 0 for every subsequent frame.
3. **Left hold:** hold btn_in[0] from cycle 10 -> left=1 one cycle after the next vsync rising edge; it stays 1 until the frame after release.
4. **Chop collapse:** two debounced chop presses within one frame -> a single one-frame chop pulse.
5. **Press on frame_tick:** chop press event coinciding with frame_tick -> chop=1 in the following frame.
6. **Repeat:** with PLAYER_INPUT_REPEAT_EN, hold chop for 10 frames -> pulses in frames 0, 3, 6, 9. Without the macro -> pulse only in frame 0.
